// File: rtl/mux_32_8_pkg.sv
// Shared types and widths for the 32-to-8 serializer.
// Build option MUX_32_8_IDLE_SYM_EN is consumed by mux_32_8.
package mux_32_8_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int CNT_W          = 2;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Byte 0 is the most significant byte: transmission order is MSB first.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [CNT_W-1:0]  idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mux_32_8_hold_reg.sv
// One-word holding register with full flag; 1-cycle write, read is combinational.
// A load on the same edge as a take keeps the register full with the new word.
module mux_32_8_hold_reg
    import mux_32_8_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              load_i,
    input  logic              take_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              full_o,
    output logic [WORD_W-1:0] data_o
);

    logic              full_q, full_d;
    logic [WORD_W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (take_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/mux_32_8.sv
// 32-bit word to 8-bit byte serializer, MSB first; first byte 1 cycle after acceptance.
// ready_in is low while the holding register is full. MUX_32_8_IDLE_SYM_EN drives IDLE_SYM when idle.
module mux_32_8
    import mux_32_8_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_SYM = 8'hBC
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [WORD_W-1:0] data_in,
    output logic              ready_in,
    output logic              valid_out,
    output logic [BYTE_W-1:0] data_out
);

`ifdef MUX_32_8_IDLE_SYM_EN
    localparam logic [BYTE_W-1:0] IDLE_DAT = IDLE_SYM;
`else
    // The parameter stays in the interface; this build always idles at zero.
    localparam logic [BYTE_W-1:0] IDLE_DAT = IDLE_SYM & 8'h00;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic              vout_q, vout_d;
    logic              rdy_q, rdy_d;

    logic              accept;
    logic              hold_load, hold_take, hold_full;
    logic [WORD_W-1:0] hold_dat;
    logic [CNT_W-1:0]  cnt_nxt;

    assign accept  = valid_in & rdy_q;
    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        vout_d    = vout_q;
        hold_load = 1'b0;
        hold_take = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    shift_d = data_in;
                    cnt_d   = '0;
                    dout_d  = word_byte(data_in, '0);
                    vout_d  = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d     = cnt_nxt;
                    dout_d    = word_byte(shift_q, cnt_nxt);
                    vout_d    = 1'b1;
                    hold_load = accept;
                end else if (hold_full) begin
                    // Word boundary with a queued word: chain it with no gap.
                    shift_d   = hold_dat;
                    cnt_d     = '0;
                    dout_d    = word_byte(hold_dat, '0);
                    vout_d    = 1'b1;
                    hold_take = 1'b1;
                    hold_load = accept;
                end else if (accept) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    dout_d  = word_byte(data_in, '0);
                    vout_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dout_d  = IDLE_DAT;
                    vout_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = IDLE_DAT;
                vout_d  = 1'b0;
            end
        endcase

        // Ready reflects the holding register's occupancy after this edge.
        rdy_d = ~(hold_load | (hold_full & ~hold_take));
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= IDLE_DAT;
            vout_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            rdy_q   <= rdy_d;
        end
    end

    mux_32_8_hold_reg u_hold (
        .clk_4f (clk_4f),
        .reset  (reset),
        .load_i (hold_load),
        .take_i (hold_take),
        .data_i (data_in),
        .full_o (hold_full),
        .data_o (hold_dat)
    );

    assign ready_in  = rdy_q;
    assign valid_out = vout_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_mux_32_8.sv
// Randomized bench for mux_32_8 against a byte-queue reference model with word loopback.
module tb_mux_32_8;

    logic        clk_4f   = 1'b0;
    logic        reset    = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in  = '0;
    logic        ready_in;
    logic        valid_out;
    logic [7:0]  data_out;

`ifdef MUX_32_8_IDLE_SYM_EN
    localparam logic [7:0] EXP_IDLE = 8'hBC;
`else
    localparam logic [7:0] EXP_IDLE = 8'h00;
`endif

    always #5 clk_4f = ~clk_4f;

    mux_32_8 dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    int          n_tests = 0;
    int          n_fail  = 0;

    // Model: bytes still owed on the wire, plus words accepted but not yet recovered.
    logic [7:0]  bq[$];
    logic [31:0] sent_q[$];
    logic        m_vld;
    logic        m_rdy;
    logic [7:0]  m_dat;
    logic [31:0] coll;
    int          coll_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        sent_q.delete();
        m_vld  = 1'b0;
        m_dat  = EXP_IDLE;
        m_rdy  = 1'b0;
        coll   = '0;
        coll_n = 0;
    endtask

    // Called at a falling edge: drive inputs, advance model, check after the next rising edge.
    task automatic tick(input logic v, input logic [31:0] d);
        logic [31:0] exp_w;
        valid_in = v;
        data_in  = d;
        if (v && m_rdy) begin
            for (int i = 3; i >= 0; i--) bq.push_back(d[i*8 +: 8]);
            sent_q.push_back(d);
        end
        if (bq.size() > 0) begin
            m_vld = 1'b1;
            m_dat = bq.pop_front();
        end else begin
            m_vld = 1'b0;
            m_dat = EXP_IDLE;
        end
        // A second word is parked whenever more than the active word's tail is owed.
        m_rdy = (bq.size() < 4);
        @(posedge clk_4f);
        @(negedge clk_4f);
        check_eq("valid_out", valid_out, m_vld);
        check_eq("data_out",  data_out,  m_dat);
        check_eq("ready_in",  ready_in,  m_rdy);
        if (valid_out === 1'b1) begin
            coll = {coll[23:0], data_out};
            coll_n++;
            if (coll_n == 4) begin
                coll_n = 0;
                check_eq("loopback_avail", sent_q.size() > 0, 1'b1);
                if (sent_q.size() > 0) begin
                    exp_w = sent_q.pop_front();
                    check_eq("loopback_word", coll, exp_w);
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] w);
        bit done = 1'b0;
        int k    = 0;
        while (!done && k < 16) begin
            done = m_rdy;
            tick(1'b1, w);
            k++;
        end
        check_eq("send_accepted", done, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid_out", valid_out, 1'b0);
        check_eq("rst_data_out",  data_out,  EXP_IDLE);
        check_eq("rst_ready_in",  ready_in,  1'b0);
        repeat (n) @(negedge clk_4f);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk_4f);
        do_reset(3);

        repeat (2) tick(1'b0, 32'h0);

        send(32'hEEFFFDCC);
        repeat (6) tick(1'b0, $urandom);

        send(32'hAA12BB00);
        send(32'h11223344);
        send(32'hDEADBEEF);
        repeat (10) tick(1'b0, $urandom);

        send(32'hEEFFFDCC);
        tick(1'b0, 32'h0);
        do_reset(2);
        repeat (8) tick(1'b0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1 + int'($urandom_range(0, 2)));
            end else if (c % 600 < 200) begin
                tick(1'b1, $urandom);
            end else begin
                tick($urandom_range(0, 3) != 0, $urandom);
            end
        end
        repeat (12) tick(1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
